serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand width in bits (legal 2..32).
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to begin one addition.
REQ-005 SHALL have port: a  input  WIDTH  operand A, sampled with accepted start.
REQ-006 SHALL have port: b  input  WIDTH  operand B, sampled with accepted start.
REQ-007 SHALL have port: cin  input  1  carry-in, sampled with accepted start.
REQ-008 SHALL have port: ready  output  1  high when idle and able to accept start.
REQ-009 SHALL have port: busy  output  1  high while bits are being processed.
REQ-010 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port: sum  output  WIDTH  registered result.
REQ-012 SHALL have port: cout  output  1  registered final carry-out.

Function
REQ-013 SHALL time-share a single 1-bit full-adder instance across all WIDTH bit positions, LSB first, one bit per clock.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start=1 at a rising edge; RUN->DONE at the edge processing bit WIDTH-1; DONE->IDLE unconditionally at the next edge.
REQ-015 SHALL, on accepting start, load a and b into internal shift registers, load cin into the carry register and clear the bit counter.
REQ-016 SHALL, each RUN cycle, feed the current LSBs and carry register to the full adder, shift the operand registers right, shift the sum bit into the MSB of an internal result register, store the carry-out, and increment the counter.
REQ-017 SHALL use a bit counter of $clog2(WIDTH) bits; the terminal count is WIDTH-1 and the counter shall not wrap inside one operation.
REQ-018 SHALL drive ready=1 only in IDLE, busy=1 only in RUN, done=1 only in DONE.
REQ-019 SHALL update sum and cout only on the edge entering DONE; they hold that value until the next completion or reset.
REQ-020 SHALL have latency: start sampled at edge E0, done high from edge E0+WIDTH to E0+WIDTH+1; back-to-back issue period WIDTH+2 cycles.
REQ-021 SHALL ignore start in RUN and DONE; operands and cin changes outside the accept edge have no effect.
REQ-022 SHALL produce sum = (a+b+cin) mod 2^WIDTH and cout = bit WIDTH of a+b+cin.

Reset
REQ-023 SHALL, on rst=1 at any time including mid-RUN, immediately force state IDLE, counter 0, carry 0, all internal registers 0, sum=0, cout=0, done=0, busy=0, ready=1.
REQ-024 SHALL NOT produce a done pulse for an operation aborted by reset.

Configuration
REQ-025 SHALL, with SERIAL_SUB_EN defined, add port sub  input  1, sampled with accepted start; sub=1 loads ~b and forces carry register to 1 (cin ignored), giving sum=(a-b) mod 2^WIDTH, cout=1 when a>=b (no borrow); sub=0 is plain addition.
REQ-026 SHALL, without SERIAL_SUB_EN, have no sub port and perform addition only; all other behaviour identical.

Verification (WIDTH=8)
REQ-027 SHALL cover: a=0x5A b=0x33 cin=0 start at E0 -> done at E8, sum=0x8D cout=0, busy high E1..E8 window, ready low until E9.
REQ-028 SHALL cover: a=0xFF b=0x01 cin=0 -> sum=0x00 cout=1; a=0xFF b=0xFF cin=1 -> sum=0xFF cout=1.
REQ-029 SHALL cover: second start with a=0x01 b=0x01 asserted during RUN of 0x5A+0x33 -> ignored, single done with sum=0x8D.
REQ-030 SHALL cover: rst pulsed while processing bit 4 -> same cycle ready=1 busy=0 sum=0x00 cout=0; no done for 20 cycles after.
REQ-031 SHALL cover: start held high continuously, random operands -> done every 10 cycles, each result matches golden model.
REQ-032 SHALL cover (SERIAL_SUB_EN): sub=1 a=0x10 b=0x01 -> sum=0x0F cout=1; sub=1 a=0x01 b=0x02 cin=0 -> sum=0xFF cout=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full adder walks WIDTH bits LSB first, one bit per clock.
// Optional SERIAL_SUB_EN adds a 'sub' input that turns the operation into a - b.

module serial_adder_ctrl_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] b_in_s;
  logic             cin_in_s, fa_s, fa_co;

`ifdef SERIAL_SUB_EN
  // Subtraction is a + ~b + 1; the incoming carry is overridden.
  assign b_in_s   = sub ? ~b : b;
  assign cin_in_s = sub ? 1'b1 : cin;
`else
  assign b_in_s   = b;
  assign cin_in_s = cin;
`endif

  serial_adder_ctrl_fa u_fa (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b_in_s;
          carry_d = cin_in_s;
          cnt_d   = {CW{1'b0}};
          res_d   = {WIDTH{1'b0}};
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end else begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      S_RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_co;
        // Counter parks on the terminal count instead of wrapping.
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_co;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8); subtraction vectors run when SERIAL_SUB_EN is defined.
module tb_serial_adder_ctrl;
  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
`ifdef SERIAL_SUB_EN
  logic       sub;
`endif
  logic       ready, busy, done;
  logic [7:0] sum;
  logic       cout;

  int n_cmp;
  int n_bad;
  logic [7:0] last_s;
  logic       last_c;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_SUB_EN
    .sub   (sub),
`endif
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One operation: accept at E0, optional stray start during RUN, then 12 idle cycles.
  task automatic op(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                    input logic isub, input bit junk, input logic [7:0] es,
                    input logic ec, input string tag);
    int  k;
    int  dones;
    bit  busy_ok;
    @(negedge clk);
    a = ia; b = ib; cin = icin; start = 1'b1;
`ifdef SERIAL_SUB_EN
    sub = isub;
`endif
    cyc();
    chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
    chk({tag, "_ready_e0"}, 32'(ready), 32'd0);
    chk({tag, "_sum_hold"}, 32'({last_c, last_s}), 32'({cout, sum}));
    start = junk;
    a = 8'h01; b = 8'h01; cin = 1'b1;
`ifdef SERIAL_SUB_EN
    sub = ~isub;
`endif
    k = 0;
    busy_ok = 1'b1;
    while (!done && k < 20) begin
      cyc();
      k++;
      if (!done && (!busy || ready)) busy_ok = 1'b0;
    end
    chk({tag, "_latency"}, 32'(k), 32'd8);
    chk({tag, "_busy_run"}, 32'(busy_ok), 32'd1);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    chk({tag, "_ready_done"}, 32'(ready), 32'd0);
    start = 1'b0;
    cyc();
    chk({tag, "_ready_e9"}, 32'(ready), 32'd1);
    chk({tag, "_done_e9"}, 32'(done), 32'd0);
    dones = 0;
    repeat (11) begin
      cyc();
      if (done) dones++;
    end
    chk({tag, "_extra_done"}, 32'(dones), 32'd0);
    last_s = es;
    last_c = ec;
  endtask

  initial begin
    int         nd;
    int         dones;
    logic [8:0] g;
    logic [8:0] expq[$];

    n_cmp = 0;
    n_bad = 0;
    last_s = 8'h00;
    last_c = 1'b0;
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
`ifdef SERIAL_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'({cout, sum}), 32'd0);
    rst = 1'b0;

    op(8'h5A, 8'h33, 1'b0, 1'b0, 1'b0, 8'h8D, 1'b0, "add5a33");
    op(8'h5A, 8'h33, 1'b0, 1'b0, 1'b1, 8'h8D, 1'b0, "stray_start");
    op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "ff_01");
    op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, "ff_ff_c1");

    // Abort while bit 4 is in flight (counter = 4 after E4).
    @(negedge clk);
    a = 8'hA5; b = 8'h3C; cin = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    #2 rst = 1'b1;
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'({cout, sum}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (20) begin
      cyc();
      if (done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    last_s = 8'h00;
    last_c = 1'b0;

    // Start held high: accepts at edges 0,10,20,30, operands scrambled every cycle.
    nd = 0;
    start = 1'b1;
    for (int t = 0; t < 40; t++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      cin = 1'($urandom);
      if (t % 10 == 0) begin
        g = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        expq.push_back(g);
      end
      cyc();
      if (done) begin
        chk("b2b_phase", 32'(t % 10), 32'd8);
        if (nd < expq.size()) chk("b2b_result", 32'({cout, sum}), 32'(expq[nd]));
        nd++;
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(nd), 32'd4);
    repeat (12) cyc();
    last_s = expq[3][7:0];
    last_c = expq[3][8];

`ifdef SERIAL_SUB_EN
    op(8'h10, 8'h01, 1'b0, 1'b1, 1'b0, 8'h0F, 1'b1, "sub_10_01");
    op(8'h01, 8'h02, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, "sub_01_02");
    op(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 8'h03, 1'b0, "nosub_01_02");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
